regfile_loader: RTL and testbench



---
 rtl/regfile_loader_pkg.sv | 25 ++
 rtl/regfile_loader_if.sv | 34 +++
 rtl/regfile_loader.sv | 108 ++++++++++
 tb/tb_regfile_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_loader_pkg.sv
// rtl/regfile_loader_pkg.sv - shared constants and state encoding for regfile_loader
// Contents: stream/register-file widths, frame depth, frame counter width,
// FSM state values and the state_t enum built from them.
package regfile_loader_pkg;

  localparam int DATA_W      = 8;
  localparam int DEPTH       = 16;  // entries per frame, power of two
  localparam int ADDR_W      = 4;   // log2(DEPTH)
  localparam int FRAME_CNT_W = 8;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] PAD  = 3'd2;
  localparam logic [2:0] KICK = 3'd3;
  localparam logic [2:0] WAIT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = IDLE,
    S_LOAD = LOAD,
    S_PAD  = PAD,
    S_KICK = KICK,
    S_WAIT = WAIT
  } state_t;

endpackage

// File: rtl/regfile_loader_if.sv
// rtl/regfile_loader_if.sv - byte stream, register file write port and processor handshake bundle
// Signals:
//   in_data/in_valid/in_last/in_ready  byte stream into the loader
//   W_Addr/W_Data/W_en                 register file write port
//   go/done                            processor start pulse / completion pulse
//   busy/pad_cnt/frame_cnt             loader status
// Modports: slave = loader side, master = stream source / processor side.
interface regfile_loader_if;
  import regfile_loader_pkg::*;

  logic [DATA_W-1:0]      in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic [ADDR_W-1:0]      W_Addr;
  logic [DATA_W-1:0]      W_Data;
  logic                   W_en;
  logic                   go;
  logic                   done;
  logic                   busy;
  logic [ADDR_W:0]        pad_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport slave (
    input  in_data, in_valid, in_last, done,
    output in_ready, W_Addr, W_Data, W_en, go, busy, pad_cnt, frame_cnt
  );

  modport master (
    output in_data, in_valid, in_last, done,
    input  in_ready, W_Addr, W_Data, W_en, go, busy, pad_cnt, frame_cnt
  );

endinterface

// File: rtl/regfile_loader.sv
// rtl/regfile_loader.sv - loads a byte frame into the 16x8 register file and kicks the processor
// Ports:
//   Clk  rising-edge clock
//   Rst  synchronous active-high reset
//   bus  regfile_loader_if.slave: stream in, register file write port,
//        go/done handshake with the processor, busy/pad_cnt/frame_cnt status
// Every output is registered. Writes trail their acceptance by one cycle, so
// go (issued from KICK) lands on the cycle after the final write.
module regfile_loader
  import regfile_loader_pkg::*;
(
  input logic              Clk,
  input logic              Rst,
  regfile_loader_if.slave  bus
);

  localparam logic [ADDR_W:0] WR_LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t          state;
  logic [ADDR_W:0] wr_idx;
  logic            done_q;
  logic            accept;
  logic            done_rise;

  assign accept    = bus.in_valid && bus.in_ready;
  assign done_rise = bus.done && !done_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= S_IDLE;
      wr_idx        <= '0;
      done_q        <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.W_en      <= 1'b0;
      bus.go        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.W_Addr    <= '0;
      bus.W_Data    <= '0;
      bus.pad_cnt   <= '0;
      bus.frame_cnt <= '0;
    end else begin
      bus.W_en <= 1'b0;
      bus.go   <= 1'b0;
      done_q   <= bus.done;

      case (state)
        // IDLE and LOAD share the write path: wr_idx is 0 in IDLE, so the
        // first accepted byte lands in entry 0.
        S_IDLE, S_LOAD: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            bus.W_en   <= 1'b1;
            bus.W_Addr <= wr_idx[ADDR_W-1:0];
            bus.W_Data <= bus.in_data;
            wr_idx     <= wr_idx + 1'b1;
            bus.busy   <= 1'b1;
            if (wr_idx == WR_LAST) begin
              // Full frame; in_last here is redundant.
              state        <= S_KICK;
              bus.in_ready <= 1'b0;
              bus.pad_cnt  <= '0;
            end else if (bus.in_last) begin
              // k = wr_idx+1 bytes received, DEPTH-k entries to zero-fill.
              state        <= S_PAD;
              bus.in_ready <= 1'b0;
              bus.pad_cnt  <= WR_LAST - wr_idx;
            end else begin
              state <= S_LOAD;
            end
          end
        end

        S_PAD: begin
          bus.W_en   <= 1'b1;
          bus.W_Addr <= wr_idx[ADDR_W-1:0];
          bus.W_Data <= '0;
          wr_idx     <= wr_idx + 1'b1;
          if (wr_idx == WR_LAST) begin
            state <= S_KICK;
          end
        end

        S_KICK: begin
          bus.go <= 1'b1;
          state  <= S_WAIT;
        end

        S_WAIT: begin
          if (done_rise) begin
            state         <= S_IDLE;
            wr_idx        <= '0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            bus.frame_cnt <= bus.frame_cnt + 1'b1;
          end
        end

        default: begin
          state        <= S_IDLE;
          wr_idx       <= '0;
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_loader.sv
// tb/tb_regfile_loader.sv - self-checking bench for regfile_loader
module tb_regfile_loader;
  import regfile_loader_pkg::*;

  logic Clk;
  logic Rst;

  regfile_loader_if bus();

  regfile_loader dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a timeline of expected events keyed by cycle number.
  bit         exp_w [int];
  int         exp_a [int];
  logic [7:0] exp_d [int];
  bit         exp_g [int];

  int         m_k          = 0;   // bytes received in the open frame
  bit         m_inframe    = 0;   // frame closed, waiting for done
  bit         m_rst_recent = 0;
  bit         m_ready      = 0;
  int         m_pad        = 0;
  logic [7:0] m_frames     = 8'd0;
  int         go_cyc       = 0;
  bit         d_prev       = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    int         e;
    bit         rst_e;
    bit         acc;
    bit         dn;
    bit         rise;
    bit         last;
    logic [7:0] d;
    e     = cyc + 1;
    rst_e = Rst;
    dn    = bus.done;
    acc   = !rst_e && bus.in_valid && m_ready;
    d     = bus.in_data;
    last  = bus.in_last;
    rise  = dn && !d_prev;
    @(posedge Clk);
    #1;
    cyc = e;
    if (rst_e) begin
      exp_w.delete(); exp_a.delete(); exp_d.delete(); exp_g.delete();
      m_k = 0; m_inframe = 0; m_rst_recent = 1; m_pad = 0; m_frames = 8'd0; d_prev = 0;
    end else begin
      m_rst_recent = 0;
      if (rise && m_inframe && e > go_cyc) begin
        m_inframe = 0;
        m_frames  = m_frames + 8'd1;
      end
      d_prev = dn;
      if (acc) begin
        exp_w[e] = 1; exp_a[e] = m_k; exp_d[e] = d;
        m_k++;
        if (m_k == DEPTH || last) begin
          for (int j = m_k; j < DEPTH; j++) begin
            int c;
            c = e + j - m_k + 1;
            exp_w[c] = 1; exp_a[c] = j; exp_d[c] = 8'h00;
          end
          go_cyc = e + DEPTH - m_k + 1;
          exp_g[go_cyc] = 1;
          m_pad     = DEPTH - m_k;
          m_inframe = 1;
          m_k       = 0;
        end
      end
    end
    m_ready = !m_inframe && !m_rst_recent;

    chk("w_en", bus.W_en, exp_w.exists(cyc));
    if (exp_w.exists(cyc)) begin
      chk("w_addr", bus.W_Addr, exp_a[cyc]);
      chk("w_data", bus.W_Data, exp_d[cyc]);
    end
    chk("go", bus.go, exp_g.exists(cyc));
    chk("in_ready", bus.in_ready, m_ready);
    chk("busy", bus.busy, (m_k != 0) || m_inframe);
    chk("pad_cnt", bus.pad_cnt, m_pad);
    chk("frame_cnt", bus.frame_cnt, m_frames);
    if (exp_w.exists(cyc)) begin
      exp_w.delete(cyc); exp_a.delete(cyc); exp_d.delete(cyc);
    end
    if (exp_g.exists(cyc)) exp_g.delete(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, input bit gapped);
    int t;
    bit was;
    if (gapped) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    t = 0;
    while (1) begin
      was = m_ready;
      tick();
      if (was) break;
      t++;
      if (t > 200) begin
        chk("accept_timeout", t, 0);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic finish_frame(input int extra, input int hold);
    idle(DEPTH + 2 + extra);
    bus.done = 1'b1;
    idle(hold);
    bus.done = 1'b0;
    tick();
  endtask

  task automatic send_frame(input int len, input bit gapped);
    for (int i = 0; i < len; i++) begin
      bit l;
      l = (i == len - 1) ? ((len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      send_byte(8'($urandom), l, gapped ? 1'b1 : 1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    Rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = 8'h00; bus.done = 1'b0;
    idle(2);
    chk("rst_w_addr", bus.W_Addr, 0);
    chk("rst_w_data", bus.W_Data, 0);
    Rst = 1'b0;
    tick();
    chk("rst_release_ready", bus.in_ready, 1);

    // Full frame 0x01..0x10, continuous
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i + 1), 1'b0, 1'b0);
    idle(20);
    bus.done = 1'b1; tick(); bus.done = 1'b0; tick();
    chk("full_frame_cnt", bus.frame_cnt, 1);

    // Short frame 07 09 0B
    send_byte(8'h07, 1'b0, 1'b0);
    send_byte(8'h09, 1'b0, 1'b0);
    send_byte(8'h0B, 1'b1, 1'b0);
    chk("short_pad_cnt", bus.pad_cnt, 13);
    finish_frame(3, 1);

    // Backpressure: byte held through KICK and WAIT
    send_frame(DEPTH, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.in_last = 1'b0;
    idle(DEPTH + 6);
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    send_byte(8'hA5, 1'b0, 1'b0);
    chk("held_byte_addr", bus.W_Addr, 0);
    chk("held_byte_data", bus.W_Data, 8'hA5);
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b0);
    finish_frame(0, 1);

    // Gapped 16-byte frame, then done held 3 cycles, then a stray done in IDLE
    send_frame(DEPTH, 1'b1);
    finish_frame(2, 3);
    chk("done_held_cnt", bus.frame_cnt, 5);
    bus.done = 1'b1; tick(); bus.done = 1'b0; idle(2);
    chk("idle_done_cnt", bus.frame_cnt, 5);

    // Single-byte frame and 16th byte carrying in_last
    send_byte(8'hEE, 1'b1, 1'b0);
    chk("one_byte_pad", bus.pad_cnt, 15);
    finish_frame(0, 1);
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'hC0 + i), i == DEPTH - 1, 1'b0);
    chk("last16_pad", bus.pad_cnt, 0);
    finish_frame(1, 2);

    // Reset mid-LOAD after 5 bytes
    for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i), 1'b0, 1'b0);
    Rst = 1'b1; tick();
    chk("midrst_w_addr", bus.W_Addr, 0);
    Rst = 1'b0; tick();
    send_frame(6, 1'b0);
    finish_frame(0, 1);

    // Random frames
    for (int f = 0; f < 30; f++) begin
      send_frame($urandom_range(1, DEPTH), 1'($urandom_range(0, 1)));
      finish_frame($urandom_range(0, 10), $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        bus.done = 1'b1; tick(); bus.done = 1'b0; tick();
      end
    end

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
